// File: rtl/cmac_tx_pkt_arbiter.sv
// Packet-atomic round-robin arbiter sharing the qsfp0 CMAC TX AXI-Stream among NUM_SRC requesters.
// Over-length packets are cut at MAX_BEATS with tlast+tuser, and the remainder is drained.
module cmac_tx_pkt_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 512,
  parameter int KEEP_W    = 64,
  parameter int MAX_BEATS = 24
) (
  input  logic                         qsfp0_tx_clk_int,
  input  logic                         qsfp0_tx_rst_int,
  input  logic [NUM_SRC*DATA_W-1:0]    s_axis_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0]    s_axis_tkeep,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  input  logic [NUM_SRC-1:0]           s_axis_tuser,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [DATA_W-1:0]            m_axis_tdata,
  output logic [KEEP_W-1:0]            m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy,
  output logic [31:0]                  pkt_cnt,
  output logic [15:0]                  trunc_cnt
);

  // state | meaning
  // IDLE  | no packet owned; pick next requester after rr pointer
  // PASS  | granted source's packet flows to the MAC
  // DRAIN | packet was truncated; swallow source beats up to its tlast

  localparam int IDX_W  = $clog2(NUM_SRC);
  localparam int BCNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DRAIN} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_grant;
  logic [IDX_W-1:0]    r_rr_ptr;
  logic [BCNT_W-1:0]   r_beat_cnt;
  logic [31:0]         r_pkt_cnt;
  logic [15:0]         r_trunc_cnt;

  logic [IDX_W-1:0]    w_next_grant;
  logic                w_req_any;
  logic [DATA_W-1:0]   w_g_data;
  logic [KEEP_W-1:0]   w_g_keep;
  logic                w_g_last;
  logic                w_g_user;
  logic                w_g_valid;
  logic                w_at_limit;
  logic                w_trunc;
  logic                w_hs;

  // Search upward from rr_ptr+1 so the last winner gets lowest priority.
  always_comb begin
    logic [IDX_W-1:0] w_cand;
    w_cand       = '0;
    w_next_grant = '0;
    w_req_any    = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_cand = IDX_W'((int'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_req_any && s_axis_tvalid[w_cand]) begin
        w_next_grant = w_cand;
        w_req_any    = 1'b1;
      end
    end
  end

  assign w_g_data   = s_axis_tdata[r_grant*DATA_W +: DATA_W];
  assign w_g_keep   = s_axis_tkeep[r_grant*KEEP_W +: KEEP_W];
  assign w_g_last   = s_axis_tlast[r_grant];
  assign w_g_user   = s_axis_tuser[r_grant];
  assign w_g_valid  = s_axis_tvalid[r_grant];
  assign w_at_limit = (r_beat_cnt == BCNT_W'(MAX_BEATS - 1));
  assign w_trunc    = w_at_limit & ~w_g_last;
  assign w_hs       = (r_state == S_PASS) & w_g_valid & m_axis_tready;

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (r_state == S_PASS) begin
      m_axis_tdata           = w_g_data;
      m_axis_tkeep           = w_g_keep;
      m_axis_tlast           = w_g_last | w_trunc;
      m_axis_tuser           = w_g_user | w_trunc;
      m_axis_tvalid          = w_g_valid;
      s_axis_tready[r_grant] = m_axis_tready;
    end else if (r_state == S_DRAIN) begin
      s_axis_tready[r_grant] = 1'b1;
    end
  end

  always_ff @(posedge qsfp0_tx_clk_int or posedge qsfp0_tx_rst_int) begin
    if (qsfp0_tx_rst_int) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= IDX_W'(NUM_SRC - 1);
      r_beat_cnt  <= '0;
      r_pkt_cnt   <= '0;
      r_trunc_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant    <= w_next_grant;
            r_beat_cnt <= '0;
            r_state    <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_g_last) begin
              r_pkt_cnt <= r_pkt_cnt + 32'd1;
              r_rr_ptr  <= r_grant;
              r_state   <= S_IDLE;
            end else if (w_at_limit) begin
              r_pkt_cnt <= r_pkt_cnt + 32'd1;
              if (r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 16'd1;
              r_state   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_g_valid && w_g_last) begin
            r_rr_ptr <= r_grant;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant_idx = r_grant;
  assign busy      = (r_state != S_IDLE);
  assign pkt_cnt   = r_pkt_cnt;
  assign trunc_cnt = r_trunc_cnt;

endmodule

// File: doc/cmac_tx_pkt_arbiter.md
Name: cmac_tx_pkt_arbiter

Overview:
Packet-atomic round-robin arbiter that shares the qsfp0 CMAC TX AXI-Stream (512-bit) among NUM_SRC upstream requesters, e.g. pad and test-traffic generators.
- Sits between the requesters and the MAC TX port.
- Enforces a maximum packet length: an over-length packet is truncated with an error marker and the rest of it is drained.
- Provides packet and truncation counters for status registers.

Parameters:
NUM_SRC, 4, number of requesting sources (2..8)
DATA_W, 512, tdata width per source
KEEP_W, 64, tkeep width per source (DATA_W/8)
MAX_BEATS, 24, maximum beats per forwarded packet (>=2)

Ports:
qsfp0_tx_clk_int  input  1  TX clock
qsfp0_tx_rst_int  input  1  asynchronous active-high reset
s_axis_tdata  input  NUM_SRC*DATA_W  source data, source i at [i*DATA_W +: DATA_W]
s_axis_tkeep  input  NUM_SRC*KEEP_W  source byte enables
s_axis_tlast  input  NUM_SRC  source end of packet
s_axis_tuser  input  NUM_SRC  source error flag
s_axis_tvalid  input  NUM_SRC  source valid
s_axis_tready  output  NUM_SRC  source ready
m_axis_tdata  output  DATA_W  to MAC TX
m_axis_tkeep  output  KEEP_W  to MAC TX
m_axis_tlast  output  1  to MAC TX
m_axis_tuser  output  1  to MAC TX (1 = bad frame)
m_axis_tvalid  output  1  to MAC TX
m_axis_tready  input  1  from MAC TX
grant_idx  output  $clog2(NUM_SRC)  currently/last granted source
busy  output  1  state != IDLE
pkt_cnt  output  32  packets completed on master (wraps)
trunc_cnt  output  16  truncated packets (saturates at 0xFFFF)

Behaviour:
- Clock and reset: clock qsfp0_tx_clk_int; reset qsfp0_tx_rst_int, asynchronous, active-high.
- Reset values:
  - state=IDLE, grant_idx=0, rr pointer=NUM_SRC-1 (so source 0 has first priority), beat_cnt=0, pkt_cnt=0, trunc_cnt=0.
  - m_axis_tvalid=0, s_axis_tready=all 0, busy=0.
  - m_axis_tdata/tkeep/tlast/tuser=0 while not in PASS.
- States: IDLE, PASS, DRAIN.
- IDLE:
  - All s_axis_tready=0, m_axis_tvalid=0.
  - If any s_axis_tvalid is set, register grant_idx = first asserted source searching upward from rr_ptr+1 (mod NUM_SRC), clear beat_cnt, go to PASS.
  - Arbitration costs one idle cycle per packet; that bubble is accepted.
- PASS:
  - m_axis_* = source grant_idx fields combinationally.
  - m_axis_tvalid = s_axis_tvalid[grant].
  - s_axis_tready[grant] = m_axis_tready; all other readys are 0.
  - Handshake = m_axis_tvalid & m_axis_tready. Each handshake increments beat_cnt.
  - Handshake with source tlast=1: pkt_cnt+1, rr_ptr=grant_idx, go to IDLE.
  - Handshake with tlast=0 and beat_cnt==MAX_BEATS-1: force m_axis_tlast=1 and m_axis_tuser=1 on that beat, pkt_cnt+1, trunc_cnt+1 (saturating), go to DRAIN.
  - Source tlast=1 on the MAX_BEATS-th beat is a normal end; no truncation.
  - tvalid low mid-packet: hold PASS, no switch to another source (packet atomicity).
- DRAIN:
  - m_axis_tvalid=0.
  - s_axis_tready[grant]=1 unconditionally; accepted beats are discarded.
  - On accepted beat with tlast=1: rr_ptr=grant_idx, go to IDLE.
- grant_idx holds its value in IDLE until the next grant.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is dropped, with no tlast emitted.
- Simultaneous requests are resolved by the round-robin pointer only.
- Single-beat packet (tlast on first beat): PASS for exactly 1 handshake cycle, then IDLE.

Test Plan:
- Single source 0 sends a 3-beat packet, m_axis_tready=1 → grant_idx=0, 1 idle cycle then 3 beats output, tlast on beat 3, pkt_cnt=1.
- Sources 0,1,2 all request 2-beat packets continuously → grant order 0,1,2,0,…; never interleaved; 3 cycles per packet; pkt_cnt=6 after 6 packets.
- Source 1 sends a 30-beat packet with MAX_BEATS=24 → 24 beats output, beat 24 tlast=1 and tuser=1; remaining 6 beats accepted and dropped; trunc_cnt=1; next source served afterward.
- m_axis_tready toggled randomly while source 3 sends 5 beats with tvalid gaps → output data order intact, s_axis_tready[3] equals m_axis_tready, other readys 0, no beat duplicated or lost.
- Reset pulsed while in PASS at beat 2 of 4 → m_axis_tvalid=0 and all readys 0 immediately, counters=0; after release, source 0 wins first.
- Source 2 sends a 1-beat packet with tuser=1 → output tuser=1, trunc_cnt unchanged, pkt_cnt+1.
